excp_ctrl: RTL
==============

Name: excp_ctrl

Overview:
- Exception/interrupt sequencer sitting between the pipeline stages and the CSR file.
- Arbitrates simultaneous exception requests from NUM_SRC pipeline stages, qualifies pending interrupts against CRMD.IE, ECFG.LIE and ESTAT.IS, and handles ERTN.
- Issues exactly one single-cycle excp_flush/ertn_flush to the CSR file per event, with ecode/esubcode/era.
- Then holds a redirect handshake to fetch and a drain window before accepting the next event.

Parameters:
NUM_SRC, 4, number of exception sources; index 0 = oldest instruction = highest priority
DRAIN_CYCLES, 2, cycles pipe_stall stays high after redirect acceptance (1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
src_valid  input  NUM_SRC  per-stage exception request, level, held by source until flushed
src_ecode  input  NUM_SRC*6  packed ecodes, source i at [6i+5:6i]
src_esubcode  input  NUM_SRC*9  packed esubcodes
src_pc  input  NUM_SRC*32  packed faulting PCs
ertn_req  input  1  ERTN reached commit
commit_valid  input  1  an instruction commits this cycle
commit_pc  input  32  PC of committing instruction
crmd_ie  input  1  CRMD.IE
ecfg_lie  input  13  ECFG.LIE
estat_is  input  13  ESTAT.IS
excp_flush  output  1  1-cycle pulse to CSR
ertn_flush  output  1  1-cycle pulse to CSR
ecode_out  output  6  valid with excp_flush
esubcode_out  output  9  valid with excp_flush
era_out  output  32  valid with excp_flush
redirect_valid  output  1  fetch redirect request
redirect_sel  output  1  0 = EENTRY target, 1 = ERA target
redirect_ready  input  1  fetch accepts redirect
pipe_stall  output  1  freeze/kill younger stages
busy  output  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, drain counter 0. Reset asserted in any state returns to IDLE immediately (async).
- int_pend = crmd_ie & |(ecfg_lie & estat_is).
- Selection in IDLE only; priority: interrupt (needs commit_valid) > lowest-index src_valid > ertn_req.
  - Interrupt: ecode 6'h0, esub 0, era = commit_pc.
  - Exception: selected source's fields.
  - ertn_req with no exception/interrupt: ertn_flush path.
- int_pend without commit_valid waits; it is never attached to a non-committing PC.
- Requests arriving in any non-IDLE state are ignored. Sources must hold; they are re-sampled on return to IDLE.
- FSM:
  - IDLE: on a selected event, register the payload and go to FLUSH.
  - FLUSH: one cycle; excp_flush xor ertn_flush = 1; ecode/esub/era driven from registers (era_out = 0 for ERTN); pipe_stall = 1; next REDIRECT.
  - REDIRECT: redirect_valid = 1, redirect_sel = 1 for ERTN, else 0; pipe_stall = 1.
    - Payload stable while valid & !ready.
    - On valid & ready, load counter = DRAIN_CYCLES and go to DRAIN.
  - DRAIN: pipe_stall = 1; counter decrements each cycle; at counter == 1, next IDLE.
- Latency: event in IDLE at cycle N → flush at N+1 → redirect_valid from N+2.
  - Minimum IDLE-to-IDLE: 3 + DRAIN_CYCLES cycles with ready tied high.
- Payload registers are 6/9/32 bits; no arithmetic on PCs.

Optional Feature:
- Macro EXCP_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_excp_cnt[31:0] and perf_int_cnt[31:0].
  - Counters increment on each excp_flush (instruction exception and interrupt respectively), saturate at 32'hFFFF_FFFF, and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package excp_pkg:
  - ecode constants: ECODE_INT=6'h0, ECODE_ADEF=6'h8, ECODE_ALE=6'h9, ECODE_SYS=6'hB, ECODE_BRK=6'hC, ECODE_INE=6'hD.
  - State enum {IDLE, FLUSH, REDIRECT, DRAIN}.
  - Width constants ECODE_W=6, ESUB_W=9, INT_W=13.
- Sub-module excp_prio_enc: parameterised fixed-priority encoder, src_valid → one-hot grant + index + any.

Test Plan:
- src_valid=4'b0110, src1 ecode 6'hB pc 32'h1C00_0010, src2 ecode 6'hD → flush at N+1, ecode 6'hB, era 32'h1C00_0010, redirect_sel 0.
- crmd_ie=1, ecfg_lie[11]=1, estat_is[11]=1, commit_valid=1, commit_pc 32'h1C00_0040, src_valid=4'b0001 → interrupt wins: ecode 0, era 32'h1C00_0040. Repeat with crmd_ie=0 → src0 exception taken.
- ertn_req alone → ertn_flush pulse, excp_flush 0, redirect_sel 1. ertn_req with src3 valid → exception wins.
- redirect_ready low for 5 cycles → redirect_valid and sel held, pipe_stall 1; new src_valid ignored; after acceptance pipe_stall stays 1 for exactly DRAIN_CYCLES=2 cycles.
- reset low during REDIRECT → all outputs 0 asynchronously; after release, held src_valid re-triggers a flush.
- With EXCP_CTRL_PERF_CNT_EN: 3 exceptions + 1 interrupt → perf_excp_cnt=3, perf_int_cnt=1. Preload to 32'hFFFF_FFFF → stays saturated.

Source files
------------

// File: rtl/excp_pkg.sv
// excp_ctrl shared types and constants.
// Ecode values, payload widths, FSM states, event kinds.
package excp_pkg;

  localparam int ECODE_W = 6;
  localparam int ESUB_W  = 9;
  localparam int INT_W   = 13;

  localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h0;
  localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h8;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h9;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'hB;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'hC;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'hD;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    KIND_EXC,
    KIND_INT,
    KIND_ERTN
  } kind_e;

endpackage

// File: rtl/excp_prio_enc.sv
// Fixed-priority encoder: lowest index wins.
// Ports: req in, gnt one-hot, idx of winner, any request.
module excp_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt/ERTN sequencer: flush pulse, redirect, drain.
// Ports: clk, reset (async low), per-source requests, commit info,
// CSR interrupt state; flush pulses + payload, redirect handshake,
// pipe_stall, busy. EXCP_CTRL_PERF_CNT_EN adds perf_excp_cnt and
// perf_int_cnt.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ECODE_W-1:0] src_ecode,
  input  logic [NUM_SRC*ESUB_W-1:0] src_esubcode,
  input  logic [NUM_SRC*32-1:0]     src_pc,
  input  logic                      ertn_req,
  input  logic                      commit_valid,
  input  logic [31:0]               commit_pc,
  input  logic                      crmd_ie,
  input  logic [INT_W-1:0]          ecfg_lie,
  input  logic [INT_W-1:0]          estat_is,
  output logic                      excp_flush,
  output logic                      ertn_flush,
  output logic [ECODE_W-1:0]        ecode_out,
  output logic [ESUB_W-1:0]         esubcode_out,
  output logic [31:0]               era_out,
  output logic                      redirect_valid,
  output logic                      redirect_sel,
  input  logic                      redirect_ready,
  output logic                      pipe_stall,
  output logic                      busy
`ifdef EXCP_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]               perf_excp_cnt,
  output logic [31:0]               perf_int_cnt
`endif
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_e state;
  kind_e  kind_q;
  logic [3:0] cnt;

  logic [NUM_SRC-1:0] src_gnt;
  logic [IW-1:0]      unused_idx;
  logic               exc_any;
  logic               int_pend;
  logic               take_int;

  logic [ECODE_W-1:0] sel_ecode;
  logic [ESUB_W-1:0]  sel_esub;
  logic [31:0]        sel_pc;

  excp_prio_enc #(.N(NUM_SRC), .IW(IW)) u_prio (
    .req (src_valid),
    .gnt (src_gnt),
    .idx (unused_idx),
    .any (exc_any)
  );

  assign int_pend = crmd_ie & |(ecfg_lie & estat_is);
  // Interrupts only attach to a committing instruction's PC.
  assign take_int = int_pend & commit_valid;

  always_comb begin
    sel_ecode = '0;
    sel_esub  = '0;
    sel_pc    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_gnt[i]) begin
        sel_ecode = src_ecode[i*ECODE_W +: ECODE_W];
        sel_esub  = src_esubcode[i*ESUB_W +: ESUB_W];
        sel_pc    = src_pc[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      kind_q         <= KIND_EXC;
      cnt            <= '0;
      excp_flush     <= 1'b0;
      ertn_flush     <= 1'b0;
      ecode_out      <= '0;
      esubcode_out   <= '0;
      era_out        <= '0;
      redirect_valid <= 1'b0;
      redirect_sel   <= 1'b0;
      pipe_stall     <= 1'b0;
      busy           <= 1'b0;
`ifdef EXCP_CTRL_PERF_CNT_EN
      perf_excp_cnt  <= '0;
      perf_int_cnt   <= '0;
`endif
    end else begin
      // Payload outputs are only meaningful for the flush cycle.
      excp_flush   <= 1'b0;
      ertn_flush   <= 1'b0;
      ecode_out    <= '0;
      esubcode_out <= '0;
      era_out      <= '0;
      unique case (state)
        IDLE: begin
          if (take_int || exc_any || ertn_req) begin
            state      <= FLUSH;
            pipe_stall <= 1'b1;
            busy       <= 1'b1;
          end
          if (take_int) begin
            kind_q     <= KIND_INT;
            excp_flush <= 1'b1;
            ecode_out  <= ECODE_INT;
            era_out    <= commit_pc;
          end else if (exc_any) begin
            kind_q       <= KIND_EXC;
            excp_flush   <= 1'b1;
            ecode_out    <= sel_ecode;
            esubcode_out <= sel_esub;
            era_out      <= sel_pc;
          end else if (ertn_req) begin
            kind_q     <= KIND_ERTN;
            ertn_flush <= 1'b1;
          end
        end
        FLUSH: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_sel   <= (kind_q == KIND_ERTN);
`ifdef EXCP_CTRL_PERF_CNT_EN
          if (kind_q == KIND_EXC && perf_excp_cnt != '1)
            perf_excp_cnt <= perf_excp_cnt + 32'd1;
          if (kind_q == KIND_INT && perf_int_cnt != '1)
            perf_int_cnt <= perf_int_cnt + 32'd1;
`endif
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= DRAIN;
            redirect_valid <= 1'b0;
            redirect_sel   <= 1'b0;
            cnt            <= 4'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= IDLE;
            pipe_stall <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
